// File: rtl/mc_mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset computer:
// opcode/funct codes, control-state encoding and ALU operation encoding.
package mc_mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Multi-cycle control steps
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // ALU operations
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

endpackage

// File: rtl/mc_unified_mem.sv
// Unified instruction/data memory: combinational read, synchronous write.
// Word-addressed by addr_i[MEM_AW+1:2]; higher address bits wrap around.
// Contents are never touched by reset; the array name dmem is fixed so the
// program image can be preloaded hierarchically.
module mc_unified_mem #(
  parameter int MEM_DEPTH = 128,
  parameter int MEM_AW    = 7
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0]       dmem [0:MEM_DEPTH-1];
  logic [MEM_AW-1:0] widx;
  logic              unused_addr;

  assign widx        = addr_i[MEM_AW+1:2];
  assign unused_addr = ^{addr_i[31:MEM_AW+2], addr_i[1:0]};
  assign rdata_o     = dmem[widx];

  // Word write when the core is committing a store
  always_ff @(posedge clk_i) begin
    if (we_i) dmem[widx] <= wdata_i;
  end

endmodule

// File: rtl/mc_mips_comp.sv
// Multi-cycle MIPS-subset computer: one core (IF/ID/EX/MEM/WB control steps)
// plus the unified memory U_DM. Register file and ALU are inline.
// Optional macro MCCOMP_BNE_EN: when defined, bne (opcode 6'h05) branches in
// EX when A!=B; otherwise opcode 6'h05 is an unsupported nop.
module mc_mips_comp
  import mc_mips_pkg::*;
#(
  parameter int MEM_DEPTH = 128,
  parameter int MEM_AW    = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  state_t      state_q, state_d;
  logic [31:0] PC, pc_d;
  logic [31:0] instr, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d;
  logic [31:0] gpr_q [0:31];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_we_raw, mem_we;
  logic [31:0] mem_addr, mem_rdata;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm, zext_imm, rs_val, rt_val;
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign sext_imm = {{16{instr[15]}}, instr[15:0]};
  assign zext_imm = {16'h0000, instr[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : gpr_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : gpr_q[rt];
  assign reg_data = (reg_sel == 5'd0) ? 32'h0 : gpr_q[reg_sel];

  // Instruction classes
  logic is_rfmt, is_jr, is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  assign is_rfmt = (op == OP_RTYPE) &&
                   (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR  || funct == FN_SLT);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_addi = (op == OP_ADDI);
  assign is_ori  = (op == OP_ORI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
`ifdef MCCOMP_BNE_EN
  assign is_bne  = (op == OP_BNE);
`else
  assign is_bne  = 1'b0;
`endif

  function automatic logic [31:0] alu_eval(alu_op_t fn, logic [31:0] x, logic [31:0] y);
    case (fn)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_res;
  logic        br_taken;

  // ALU operation and second operand selection for the EX step
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = sext_imm;
    if (is_rfmt) begin
      alu_b = b_q;
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (is_ori) begin
      alu_op = ALU_OR;
      alu_b  = zext_imm;
    end
  end

  assign alu_res  = alu_eval(alu_op, a_q, alu_b);
  assign br_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

  // Control sequencing and datapath next-state
  always_comb begin
    state_d    = state_q;
    pc_d       = PC;
    instr_d    = instr;
    a_d        = a_q;
    b_d        = b_q;
    aluout_d   = aluout_q;
    mdr_d      = mdr_q;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'h0;
    mem_we_raw = 1'b0;
    case (state_q)
      S_IF: begin
        instr_d = mem_rdata;
        pc_d    = PC + 32'd4;
        state_d = S_ID;
      end
      S_ID: begin
        a_d      = rs_val;
        b_d      = rt_val;
        aluout_d = PC + {sext_imm[29:0], 2'b00};
        state_d  = S_IF;
        if (is_j || is_jal) pc_d = {PC[31:28], instr[25:0], 2'b00};
        if (is_jal) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = PC;
        end
        if (is_jr) pc_d = rs_val;
        if (is_rfmt || is_addi || is_ori || is_lw || is_sw || is_beq || is_bne)
          state_d = S_EX;
      end
      S_EX: begin
        if (is_beq || is_bne) begin
          if (br_taken) pc_d = aluout_q;
          state_d = S_IF;
        end else begin
          aluout_d = alu_res;
          state_d  = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end else begin
          mem_we_raw = 1'b1;
          state_d    = S_IF;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = is_rfmt ? rd : rt;
        rf_wdata = is_lw ? mdr_q : aluout_q;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // A reset edge aborts any store that would otherwise commit on it
  assign mem_we   = mem_we_raw & ~rstn;
  assign mem_addr = (state_q == S_MEM) ? aluout_q : PC;

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= S_IF;
      PC       <= 32'h0;
      instr    <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      aluout_q <= 32'h0;
      mdr_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      PC       <= pc_d;
      instr    <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  // Register file; $0 is never written
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      gpr_q[rf_waddr] <= rf_wdata;
    end
  end

  mc_unified_mem #(
    .MEM_DEPTH(MEM_DEPTH),
    .MEM_AW   (MEM_AW)
  ) U_DM (
    .clk_i  (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(b_q),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_mc_mips_comp.sv
// Directed-vector bench for mc_mips_comp. Programs are poked into U_DM.dmem
// while reset is held; results are read back through the debug port.
module tb_mc_mips_comp;
  import mc_mips_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  int          checks = 0;
  int          failures = 0;

  mc_mips_comp dut (
    .clk     (clk),
    .rstn    (rstn),
    .reg_sel (reg_sel),
    .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Hold reset for two edges and clear memory; leaves rstn=1 at a negedge
  task automatic start_prog;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 128; i++) dut.U_DM.dmem[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_add;
    start_prog();
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    dut.U_DM.dmem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    dut.U_DM.dmem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    rstn = 1'b0;
    run(11);
    reg_sel = 5'd3; #1;
    checks++;
    if (reg_data !== 32'h0) begin failures++; $display("FAIL add_r3_early got=%h exp=%h", reg_data, 32'h0); end
    run(1);
    reg_sel = 5'd3; #1;
    checks++;
    if (reg_data !== 32'h2) begin failures++; $display("FAIL add_r3 got=%h exp=%h", reg_data, 32'h2); end
    reg_sel = 5'd2; #1;
    checks++;
    if (reg_data !== 32'hFFFFFFFD) begin failures++; $display("FAIL addi_r2 got=%h exp=%h", reg_data, 32'hFFFFFFFD); end
    checks++;
    if (dut.PC !== 32'hC) begin failures++; $display("FAIL add_pc got=%h exp=%h", dut.PC, 32'hC); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", dut.PC, 32'h0); end
    checks++;
    if (dut.state_q !== S_IF) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, S_IF); end
    checks++;
    if (dut.instr !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=%h", dut.instr, 32'h0); end
    for (int r = 0; r < 32; r++) begin
      reg_sel = r[4:0]; #1;
      checks++;
      if (reg_data !== 32'h0) begin failures++; $display("FAIL reset_gpr%0d got=%h exp=%h", r, reg_data, 32'h0); end
    end
  endtask

  task automatic test_alu;
    logic [31:0] exp_r [0:8];
    exp_r = '{32'h0, 32'hFFFFFFFD, 32'h6, 32'hFFFFFFF7, 32'h4, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h00008001};
    start_prog();
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
    dut.U_DM.dmem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd6);
    dut.U_DM.dmem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h22);
    dut.U_DM.dmem[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h24);
    dut.U_DM.dmem[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h25);
    dut.U_DM.dmem[5] = enc_r(5'd1, 5'd2, 5'd6, 6'h2A);
    dut.U_DM.dmem[6] = enc_r(5'd2, 5'd1, 5'd7, 6'h2A);
    dut.U_DM.dmem[7] = enc_i(6'h0D, 5'd0, 5'd8, 16'h8001);
    dut.U_DM.dmem[8] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
    rstn = 1'b0;
    run(36);
    for (int r = 0; r < 9; r++) begin
      reg_sel = r[4:0]; #1;
      checks++;
      if (reg_data !== exp_r[r]) begin failures++; $display("FAIL alu_r%0d got=%h exp=%h", r, reg_data, exp_r[r]); end
    end
  endtask

  task automatic test_sw_lw;
    start_prog();
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    dut.U_DM.dmem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'h1234);
    dut.U_DM.dmem[2] = enc_i(6'h2B, 5'd1, 5'd2, 16'd0);
    dut.U_DM.dmem[3] = enc_i(6'h23, 5'd1, 5'd4, 16'd0);
    rstn = 1'b0;
    run(12);
    checks++;
    if (dut.U_DM.dmem[16] !== 32'h1234) begin failures++; $display("FAIL sw_mem got=%h exp=%h", dut.U_DM.dmem[16], 32'h1234); end
    run(4);
    reg_sel = 5'd4; #1;
    checks++;
    if (reg_data !== 32'h0) begin failures++; $display("FAIL lw_r4_early got=%h exp=%h", reg_data, 32'h0); end
    run(1);
    reg_sel = 5'd4; #1;
    checks++;
    if (reg_data !== 32'h1234) begin failures++; $display("FAIL lw_r4 got=%h exp=%h", reg_data, 32'h1234); end
    checks++;
    if (dut.PC !== 32'h10) begin failures++; $display("FAIL lw_pc got=%h exp=%h", dut.PC, 32'h10); end
  endtask

  task automatic test_loop;
    start_prog();
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd0);
    dut.U_DM.dmem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    dut.U_DM.dmem[2] = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
    dut.U_DM.dmem[3] = enc_i(6'h04, 5'd1, 5'd2, 16'd1);
    dut.U_DM.dmem[4] = enc_j(6'h02, 26'd2);
    dut.U_DM.dmem[5] = enc_j(6'h02, 26'd5);
    rstn = 1'b0;
    run(69);
    reg_sel = 5'd1; #1;
    checks++;
    if (reg_data !== 32'd7) begin failures++; $display("FAIL loop_r1 got=%h exp=%h", reg_data, 32'd7); end
    checks++;
    if (dut.PC !== 32'h14) begin failures++; $display("FAIL loop_pc got=%h exp=%h", dut.PC, 32'h14); end
    checks++;
    if (dut.state_q !== S_IF) begin failures++; $display("FAIL loop_state got=%0d exp=%0d", dut.state_q, S_IF); end
    run(4);
    checks++;
    if (dut.PC !== 32'h14) begin failures++; $display("FAIL loop_halt_pc got=%h exp=%h", dut.PC, 32'h14); end
  endtask

  task automatic test_jal_jr;
    start_prog();
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd6, 16'd3);
    dut.U_DM.dmem[1] = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    dut.U_DM.dmem[2] = enc_j(6'h03, 26'd8);
    dut.U_DM.dmem[3] = enc_r(5'd5, 5'd6, 5'd7, 6'h20);
    dut.U_DM.dmem[4] = enc_j(6'h02, 26'd4);
    dut.U_DM.dmem[8] = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
    dut.U_DM.dmem[9] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    rstn = 1'b0;
    run(10);
    checks++;
    if (dut.PC !== 32'h20) begin failures++; $display("FAIL jal_pc got=%h exp=%h", dut.PC, 32'h20); end
    reg_sel = 5'd31; #1;
    checks++;
    if (reg_data !== 32'hC) begin failures++; $display("FAIL jal_r31 got=%h exp=%h", reg_data, 32'hC); end
    run(4);
    reg_sel = 5'd5; #1;
    checks++;
    if (reg_data !== 32'd9) begin failures++; $display("FAIL sub_r5 got=%h exp=%h", reg_data, 32'd9); end
    run(2);
    checks++;
    if (dut.PC !== 32'hC) begin failures++; $display("FAIL jr_pc got=%h exp=%h", dut.PC, 32'hC); end
    run(4);
    reg_sel = 5'd7; #1;
    checks++;
    if (reg_data !== 32'd12) begin failures++; $display("FAIL ret_r7 got=%h exp=%h", reg_data, 32'd12); end
  endtask

  task automatic test_reset_mid;
    // Reset on the MEM edge of a store: memory must keep its old word
    start_prog();
    dut.U_DM.dmem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    dut.U_DM.dmem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'h0077);
    dut.U_DM.dmem[2]  = enc_i(6'h2B, 5'd1, 5'd2, 16'd0);
    dut.U_DM.dmem[16] = 32'hABCD;
    rstn = 1'b0;
    run(11);
    checks++;
    if (dut.state_q !== S_MEM) begin failures++; $display("FAIL sw_mid_state got=%0d exp=%0d", dut.state_q, S_MEM); end
    rstn = 1'b1;
    run(1);
    checks++;
    if (dut.U_DM.dmem[16] !== 32'hABCD) begin failures++; $display("FAIL sw_abort_mem got=%h exp=%h", dut.U_DM.dmem[16], 32'hABCD); end
    checks++;
    if (dut.PC !== 32'h0) begin failures++; $display("FAIL sw_abort_pc got=%h exp=%h", dut.PC, 32'h0); end
    // Reset on the MEM edge of a load: the loaded word never reaches $4
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0040);
    dut.U_DM.dmem[1] = enc_i(6'h08, 5'd0, 5'd4, 16'h0055);
    dut.U_DM.dmem[2] = enc_i(6'h23, 5'd1, 5'd4, 16'd0);
    rstn = 1'b0;
    run(11);
    reg_sel = 5'd4; #1;
    checks++;
    if (reg_data !== 32'h55) begin failures++; $display("FAIL lw_mid_r4 got=%h exp=%h", reg_data, 32'h55); end
    rstn = 1'b1;
    run(1);
    reg_sel = 5'd4; #1;
    checks++;
    if (reg_data !== 32'h0) begin failures++; $display("FAIL lw_abort_r4 got=%h exp=%h", reg_data, 32'h0); end
    checks++;
    if (dut.PC !== 32'h0) begin failures++; $display("FAIL lw_abort_pc got=%h exp=%h", dut.PC, 32'h0); end
    checks++;
    if (dut.U_DM.dmem[16] !== 32'hABCD) begin failures++; $display("FAIL lw_abort_mem got=%h exp=%h", dut.U_DM.dmem[16], 32'hABCD); end
  endtask

  task automatic test_bne;
    int          ncyc;
    logic [31:0] exp_r2;
    start_prog();
    dut.U_DM.dmem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    dut.U_DM.dmem[1] = enc_i(6'h05, 5'd1, 5'd0, 16'd1);
    dut.U_DM.dmem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
    dut.U_DM.dmem[3] = enc_i(6'h08, 5'd0, 5'd3, 16'd6);
`ifdef MCCOMP_BNE_EN
    ncyc   = 11;
    exp_r2 = 32'h0;
`else
    ncyc   = 14;
    exp_r2 = 32'h5;
`endif
    rstn = 1'b0;
    run(ncyc);
    reg_sel = 5'd2; #1;
    checks++;
    if (reg_data !== exp_r2) begin failures++; $display("FAIL op05_r2 got=%h exp=%h", reg_data, exp_r2); end
    reg_sel = 5'd3; #1;
    checks++;
    if (reg_data !== 32'h6) begin failures++; $display("FAIL op05_r3 got=%h exp=%h", reg_data, 32'h6); end
    checks++;
    if (dut.PC !== 32'h10) begin failures++; $display("FAIL op05_pc got=%h exp=%h", dut.PC, 32'h10); end
  endtask

  initial begin
    rstn    = 1'b1;
    reg_sel = 5'd0;
    test_add();
    test_reset();
    test_alu();
    test_sw_lw();
    test_loop();
    test_jal_jr();
    test_reset_mid();
    test_bne();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
